scan_mux_nx1: RTL and testbench
===============================

Name: scan_mux_nx1

Overview:
- Parametrised N-input, WIDTH-bit multiplexer with a registered output. Successor to the fixed 4:1 single-bit mux tree.
- Two modes: static select, where a selected channel is sampled every free cycle, and auto-scan, where enabled channels are visited round-robin, each for DWELL samples.
- Output uses a valid/ready handshake with backpressure.
- Sits between multi-channel sources (switch banks, sensor lanes) and a single downstream consumer.

Parameters:
- WIDTH, 1, data width per channel.
- N, 4, number of input channels (N >= 2).
- SELW, 2, select/index width; 2**SELW >= N.
- DWELL, 1, consecutive accepted samples per channel in scan mode (>= 1).

Ports:
- clk  input  1  single clock; all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- din  input  N*WIDTH  packed channels; channel k at bits [k*WIDTH +: WIDTH].
- sel  input  SELW  channel select, used in static mode.
- mode  input  1  0 = static, 1 = auto-scan.
- en_mask  input  N  per-channel enable, used in scan mode.
- out_ready  input  1  consumer accepts dout this cycle.
- dout  output  WIDTH  registered selected data.
- dout_ch  output  SELW  channel index of dout.
- dout_valid  output  1  dout/dout_ch hold a sample.
- scan_wrap  output  1  one-cycle pulse, registered with the last sample before the scan pointer wraps.

Behaviour:
- Reset (rst=1 at clk edge): dout=0, dout_ch=0, dout_valid=0, scan_wrap=0, ptr=0, dwell cnt=0, mode_q=0.
  - Reset overrides everything, including a stalled output.
- Free cycle: free = !dout_valid | out_ready.
  - Output registers, ptr, cnt and mode_q update only on free cycles.
  - When dout_valid=1 and out_ready=0, all outputs and internal state hold.
- Latency: 1 clk from input sampling to dout.
- FSM has two states, STATIC and SCAN, taken from mode on free cycles.
  - STATIC -> SCAN transition cycle: ptr and cnt are forced to 0 before channel selection, so scanning starts at the lowest enabled channel.
  - SCAN -> STATIC: static behaviour applies from that same free cycle.
- STATIC, free cycle:
  - If sel < N: dout<=din[sel], dout_ch<=sel, dout_valid<=1.
  - If sel >= N: dout_valid<=0; dout and dout_ch hold.
  - scan_wrap=0. en_mask is ignored.
- SCAN, free cycle:
  - eff = first enabled channel at or after ptr, searching ascending with wrap N-1 -> 0.
  - en_mask==0: dout_valid<=0, ptr and cnt hold, scan_wrap<=0.
  - Otherwise: dout<=din[eff], dout_ch<=eff, dout_valid<=1.
  - If eff != ptr, the dwell count restarts; the sample counts as the first for eff.
  - If this is the DWELL-th sample of eff: ptr<=nxt (first enabled channel strictly after eff, circular), cnt<=0, and scan_wrap<=1 iff nxt <= eff.
  - Otherwise: ptr<=eff, cnt<=cnt+1, scan_wrap<=0.
- scan_wrap:
  - Is 0 on every non-free cycle after it has been consumed.
  - Registered alongside its sample; held with it while stalled, then cleared on the next free cycle unless re-asserted.
- Single enabled channel: scan_wrap asserts on every DWELL-th sample.
- en_mask changes take effect on the next free cycle; no sample from a channel disabled at that cycle is emitted.
- Dwell counts accepted samples, not clock cycles; a stall never advances the scan.

Test Plan:
- Reset: rst=1 for 2 cycles with din=all 1s, mode=1, en_mask=4'b1111 -> dout=0, dout_ch=0, dout_valid=0, scan_wrap=0.
- Static (N=4, WIDTH=8): din = ch3..ch0 = 0x44,0x33,0x22,0x11; out_ready=1.
  - sel=2 -> next cycle dout=0x33, dout_ch=2, valid=1.
  - sel=0 -> dout=0x11.
- Scan (DWELL=2, en_mask=4'b1111, out_ready=1): dout_ch sequence 0,0,1,1,2,2,3,3,0,0,...
  - scan_wrap=1 only with the second ch3 sample.
- Skip/empty:
  - en_mask=4'b1010 -> dout_ch 1,1,3,3,1,...; scan_wrap with the second ch3 sample.
  - Then en_mask=0 -> dout_valid=0 next cycle.
  - Then en_mask=4'b0100 -> ch2 every sample, scan_wrap every 2nd.
- Backpressure: in scan at the first ch1 sample, out_ready=0 for 3 cycles -> dout and dout_ch stable at ch1.
  - After release: the second ch1 sample, then 2,2. Nothing skipped or duplicated.
- Reset mid-operation: during scan at ch2 with out_ready=0, rst=1 for 1 cycle -> outputs 0 next cycle.
  - After release, mode=1 -> first sample is ch0.

Source files
------------

// File: rtl/scan_mux_nx1.sv
// N-input, WIDTH-bit multiplexer with a registered valid/ready output.
// Static mode follows sel; scan mode visits enabled channels round-robin, DWELL accepted samples each.
module scan_mux_nx1 #(
    parameter int WIDTH = 1,
    parameter int N     = 4,
    parameter int SELW  = 2,
    parameter int DWELL = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   din,
    input  logic [SELW-1:0]      sel,
    input  logic                 mode,
    input  logic [N-1:0]         en_mask,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     dout,
    output logic [SELW-1:0]      dout_ch,
    output logic                 dout_valid,
    output logic                 scan_wrap
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic {
        ST_STATIC = 1'b0,
        ST_SCAN   = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              free;
    logic [SELW-1:0]   ptr_q, ptr_d, ptr_base;
    logic [CW-1:0]     cnt_q, cnt_d, cnt_base, cnt_eff;
    logic [SELW-1:0]   eff, nxt;
    logic              any_en, found_nxt;
    logic [WIDTH-1:0]  dout_d;
    logic [SELW-1:0]   dout_ch_d;
    logic              dout_valid_d, scan_wrap_d;

    // A stalled output freezes everything, so a stall never advances the scan.
    assign free = !dout_valid || out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_STATIC;
        else     state_q <= state_d;
    end

    // Next state: mode is only taken on free cycles
    always_comb begin
        state_d = state_q;
        if (free) state_d = mode ? ST_SCAN : ST_STATIC;
    end

    // Entering scan restarts from channel 0 with an empty dwell count.
    assign ptr_base = (state_q == ST_STATIC) ? '0 : ptr_q;
    assign cnt_base = (state_q == ST_STATIC) ? '0 : cnt_q;

    // Channel search: eff = first enabled at/after ptr, nxt = first enabled strictly after eff.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        any_en    = 1'b0;
        eff       = '0;
        found_nxt = 1'b0;
        nxt       = '0;
        for (int i = 0; i < N; i++) begin
            if (!any_en && en_mask[(int'(ptr_base) + i) % N]) begin
                any_en = 1'b1;
                eff    = SELW'((int'(ptr_base) + i) % N);
            end
        end
        for (int i = 1; i <= N; i++) begin
            if (!found_nxt && en_mask[(int'(eff) + i) % N]) begin
                found_nxt = 1'b1;
                nxt       = SELW'((int'(eff) + i) % N);
            end
        end
    end

    assign cnt_eff = (eff != ptr_base) ? '0 : cnt_base;

    // Output / datapath next values
    always_comb begin
        dout_d       = dout;
        dout_ch_d    = dout_ch;
        dout_valid_d = dout_valid;
        scan_wrap_d  = scan_wrap;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        if (free) begin
            scan_wrap_d = 1'b0;
            if (state_d == ST_STATIC) begin
                if (int'(sel) < N) begin
                    dout_d       = din[int'(sel)*WIDTH +: WIDTH];
                    dout_ch_d    = sel;
                    dout_valid_d = 1'b1;
                end else begin
                    dout_valid_d = 1'b0;
                end
            end else if (!any_en) begin
                dout_valid_d = 1'b0;
                ptr_d        = ptr_base;
                cnt_d        = cnt_base;
            end else begin
                dout_d       = din[int'(eff)*WIDTH +: WIDTH];
                dout_ch_d    = eff;
                dout_valid_d = 1'b1;
                if (cnt_eff == CW'(DWELL - 1)) begin
                    ptr_d       = nxt;
                    cnt_d       = '0;
                    scan_wrap_d = (nxt <= eff);
                end else begin
                    ptr_d = eff;
                    cnt_d = cnt_eff + CW'(1);
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout       <= '0;
            dout_ch    <= '0;
            dout_valid <= 1'b0;
            scan_wrap  <= 1'b0;
            ptr_q      <= '0;
            cnt_q      <= '0;
        end else begin
            dout       <= dout_d;
            dout_ch    <= dout_ch_d;
            dout_valid <= dout_valid_d;
            scan_wrap  <= scan_wrap_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_scan_mux_nx1.sv
// Self-checking bench for scan_mux_nx1 (N=4, WIDTH=8, DWELL=2): vector table plus a stall sequence.
module tb_scan_mux_nx1;

    localparam int WIDTH = 8;
    localparam int N     = 4;
    localparam int SELW  = 2;
    localparam int DWELL = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [N*WIDTH-1:0]  din;
    logic [SELW-1:0]     sel;
    logic                mode;
    logic [N-1:0]        en_mask;
    logic                out_ready;
    logic [WIDTH-1:0]    dout;
    logic [SELW-1:0]     dout_ch;
    logic                dout_valid;
    logic                scan_wrap;

    int n_tests = 0;
    int n_fail  = 0;

    scan_mux_nx1 #(.WIDTH(WIDTH), .N(N), .SELW(SELW), .DWELL(DWELL)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .sel        (sel),
        .mode       (mode),
        .en_mask    (en_mask),
        .out_ready  (out_ready),
        .dout       (dout),
        .dout_ch    (dout_ch),
        .dout_valid (dout_valid),
        .scan_wrap  (scan_wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic               rst;
        logic               mode;
        logic [SELW-1:0]    sel;
        logic [N-1:0]       en;
        logic               rdy;
        logic [N*WIDTH-1:0] din;
        logic               e_valid;
        logic [WIDTH-1:0]   e_dout;
        logic [SELW-1:0]    e_ch;
        logic               e_wrap;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] D = 32'h4433_2211;

    task automatic v(input logic r, input logic m, input logic [1:0] s, input logic [3:0] e,
                     input logic rd, input logic [31:0] dd, input logic ev, input logic [7:0] ed,
                     input logic [1:0] ec, input logic ew);
        vec_t t;
        t = '{r, m, s, e, rd, dd, ev, ed, ec, ew};
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic m, input logic [1:0] s, input logic [3:0] e,
                         input logic rd, input logic [31:0] dd);
        @(negedge clk);
        rst = r; mode = m; sel = s; en_mask = e; out_ready = rd; din = dd;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic ev, input logic [7:0] ed,
                             input logic [1:0] ec, input logic ew);
        check({tag, ".valid"}, 32'(dout_valid), 32'(ev));
        check({tag, ".wrap"},  32'(scan_wrap),  32'(ew));
        check({tag, ".dout"},  32'(dout),       32'(ed));
        check({tag, ".ch"},    32'(dout_ch),    32'(ec));
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; sel = '0; en_mask = '0; out_ready = 1'b1; din = '0;

        //  rst mode sel en      rdy din           valid dout   ch wrap
        // Reset with all-ones data and scan requested
        v(1, 1, 0, 4'b1111, 1, 32'hFFFF_FFFF, 0, 8'h00, 0, 0);
        v(1, 1, 0, 4'b1111, 1, 32'hFFFF_FFFF, 0, 8'h00, 0, 0);
        // Static select
        v(0, 0, 2, 4'b0000, 1, D, 1, 8'h33, 2, 0);
        v(0, 0, 0, 4'b0000, 1, D, 1, 8'h11, 0, 0);
        v(0, 0, 3, 4'b0000, 1, D, 1, 8'h44, 3, 0);
        // Full scan, DWELL=2, wrap only with second ch3 sample
        v(0, 1, 0, 4'b1111, 1, D, 1, 8'h11, 0, 0);
        v(0, 1, 0, 4'b1111, 1, D, 1, 8'h11, 0, 0);
        v(0, 1, 0, 4'b1111, 1, D, 1, 8'h22, 1, 0);
        v(0, 1, 0, 4'b1111, 1, D, 1, 8'h22, 1, 0);
        v(0, 1, 0, 4'b1111, 1, D, 1, 8'h33, 2, 0);
        v(0, 1, 0, 4'b1111, 1, D, 1, 8'h33, 2, 0);
        v(0, 1, 0, 4'b1111, 1, D, 1, 8'h44, 3, 0);
        v(0, 1, 0, 4'b1111, 1, D, 1, 8'h44, 3, 1);
        v(0, 1, 0, 4'b1111, 1, D, 1, 8'h11, 0, 0);
        v(0, 1, 0, 4'b1111, 1, D, 1, 8'h11, 0, 0);
        // Skip disabled channels
        v(0, 1, 0, 4'b1010, 1, D, 1, 8'h22, 1, 0);
        v(0, 1, 0, 4'b1010, 1, D, 1, 8'h22, 1, 0);
        v(0, 1, 0, 4'b1010, 1, D, 1, 8'h44, 3, 0);
        v(0, 1, 0, 4'b1010, 1, D, 1, 8'h44, 3, 1);
        v(0, 1, 0, 4'b1010, 1, D, 1, 8'h22, 1, 0);
        // Empty mask: invalid, data holds
        v(0, 1, 0, 4'b0000, 1, D, 0, 8'h22, 1, 0);
        // Single channel: wrap every second sample
        v(0, 1, 0, 4'b0100, 1, D, 1, 8'h33, 2, 0);
        v(0, 1, 0, 4'b0100, 1, D, 1, 8'h33, 2, 1);
        v(0, 1, 0, 4'b0100, 1, D, 1, 8'h33, 2, 0);
        v(0, 1, 0, 4'b0100, 1, D, 1, 8'h33, 2, 1);
        // Back to static, then rescan starts at ch0
        v(0, 0, 1, 4'b1111, 1, D, 1, 8'h22, 1, 0);
        v(0, 1, 1, 4'b1111, 1, D, 1, 8'h11, 0, 0);
        v(0, 1, 1, 4'b1111, 1, D, 1, 8'h11, 0, 0);
        v(0, 1, 1, 4'b1111, 1, D, 1, 8'h22, 1, 0);
        // Backpressure at first ch1 sample
        v(0, 1, 1, 4'b1111, 0, D, 1, 8'h22, 1, 0);
        v(0, 1, 1, 4'b1111, 0, D, 1, 8'h22, 1, 0);
        v(0, 1, 1, 4'b1111, 0, D, 1, 8'h22, 1, 0);
        v(0, 1, 1, 4'b1111, 1, D, 1, 8'h22, 1, 0);
        v(0, 1, 1, 4'b1111, 1, D, 1, 8'h33, 2, 0);
        v(0, 1, 1, 4'b1111, 1, D, 1, 8'h33, 2, 0);
        // Wrap held through a stall, cleared after
        v(0, 1, 1, 4'b1111, 1, D, 1, 8'h44, 3, 0);
        v(0, 1, 1, 4'b1111, 1, D, 1, 8'h44, 3, 1);
        v(0, 1, 1, 4'b1111, 0, D, 1, 8'h44, 3, 1);
        v(0, 1, 1, 4'b1111, 1, D, 1, 8'h11, 0, 0);
        // Reach ch2, stall, reset mid-operation
        v(0, 1, 1, 4'b1111, 1, D, 1, 8'h11, 0, 0);
        v(0, 1, 1, 4'b1111, 1, D, 1, 8'h22, 1, 0);
        v(0, 1, 1, 4'b1111, 1, D, 1, 8'h22, 1, 0);
        v(0, 1, 1, 4'b1111, 1, D, 1, 8'h33, 2, 0);
        v(0, 1, 1, 4'b1111, 0, D, 1, 8'h33, 2, 0);
        v(1, 1, 1, 4'b1111, 0, D, 0, 8'h00, 0, 0);
        v(0, 1, 1, 4'b1111, 1, D, 1, 8'h11, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].mode, vecs[i].sel, vecs[i].en, vecs[i].rdy, vecs[i].din);
            check_all($sformatf("row%0d", i), vecs[i].e_valid, vecs[i].e_dout,
                      vecs[i].e_ch, vecs[i].e_wrap);
        end

        // Static stall: sel and din changes are ignored until the consumer accepts
        drive(0, 0, 3, 4'b1111, 1, D);
        check_all("st_load", 1, 8'h44, 3, 0);
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 0, 4'b1111, 0, 32'hAABB_CCDD);
            check_all($sformatf("st_hold%0d", k), 1, 8'h44, 3, 0);
        end
        drive(0, 0, 0, 4'b1111, 1, 32'hAABB_CCDD);
        check_all("st_release", 1, 8'hDD, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
